enc_n_reg: RTL
==============

ENC_N_REG -- requirements
Module: enc_n_reg

Interface
REQ-001 The block SHALL take parameter N, default 8, giving the input vector width (power of two, 4..64).
REQ-002 The block SHALL take parameter CW, default 8, giving the error-counter width.
REQ-003 The block SHALL derive localparam W = log2(N), giving the encoded output width.
REQ-004 Port clk SHALL be an input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 Port rst SHALL be an input, 1 bit, asynchronous, active-high reset.
REQ-006 Port in_valid SHALL be an input, 1 bit, marking D as valid this cycle.
REQ-007 Port in_ready SHALL be an output, 1 bit, indicating the block accepts D this cycle.
REQ-008 Port D SHALL be an input, N bits, the request vector.
REQ-009 Port mode SHALL be an input, 1 bit: 0 = priority (highest set index wins), 1 = strict one-hot.
REQ-010 Port out_valid SHALL be an output, 1 bit, marking Y/_IN_ERR as valid.
REQ-011 Port out_ready SHALL be an input, 1 bit, the downstream accept.
REQ-012 Port Y SHALL be an output, W bits, the encoded index.
REQ-013 Port _IN_ERR SHALL be an output, 1 bit, active-low, low when the accepted D was invalid for its mode.
REQ-014 Port err_clr SHALL be an input, 1 bit, a synchronous clear of err_cnt.
REQ-015 Port err_cnt SHALL be an output, CW bits, a saturating count of accepted erroneous inputs.

Function
REQ-016 A transfer in SHALL occur when in_valid && in_ready; a transfer out SHALL occur when out_valid && out_ready.
REQ-017 in_ready SHALL equal !out_valid || out_ready (single output register; accepts when empty or draining the same cycle).
REQ-018 Latency SHALL be exactly 1 cycle: D accepted at edge k SHALL appear on Y/_IN_ERR with out_valid high after edge k.
REQ-019 out_valid SHALL set on an input transfer, clear on an output transfer with no simultaneous input transfer, and stay set on a simultaneous transfer in and out (new data replaces old).
REQ-020 While out_valid && !out_ready, Y, _IN_ERR and out_valid SHALL hold stable.
REQ-021 In mode 0 with D nonzero, Y SHALL be the highest index i with D[i]=1, and _IN_ERR SHALL be 1.
REQ-022 In mode 1, D with exactly one bit set SHALL give that index with _IN_ERR=1; D with two or more bits set SHALL give Y=0 and _IN_ERR=0.
REQ-023 D = 0 in either mode SHALL give Y=0 and _IN_ERR=0.
REQ-024 mode SHALL be sampled together with D on the input transfer only.
REQ-025 err_cnt SHALL increment by 1 on each input transfer whose result has _IN_ERR=0, and saturate at 2^CW-1.
REQ-026 err_clr SHALL zero err_cnt; if err_clr coincides with an erroneous transfer, err_cnt SHALL become 0 (clear wins).
REQ-027 No combinational path SHALL exist from D or mode to any output; out_ready to in_ready is the only combinational path.

Reset
REQ-028 On rst high, the block SHALL immediately set out_valid=0, Y=0, _IN_ERR=1 and err_cnt=0, regardless of clk.
REQ-029 Reset mid-transfer SHALL discard the held result; the first cycle after release SHALL have in_ready=1.

Structure
REQ-030 Package enc_pkg SHALL hold the mode constants (MODE_PRIO=0, MODE_ONEHOT=1) and the function computing log2 for W.
REQ-031 The combinational encode logic SHALL live in one sub-module, enc_core (params N, W; inputs D, mode; outputs Y, err_n); enc_n_reg SHALL add only the handshake register and the counter.

Verification
REQ-032 With N=8, mode 0, D=8'b0010_0110 and out_ready=1, the bench SHALL see Y=5, _IN_ERR=1, out_valid=1 one cycle later.
REQ-033 With mode 1: D=8'b0000_1000 SHALL give Y=3, _IN_ERR=1; D=8'b0000_1001 SHALL give Y=0, _IN_ERR=0 and err_cnt+1; D=0 SHALL give Y=0, _IN_ERR=0.
REQ-034 Backpressure: with out_ready=0 for 3 cycles after a transfer, the bench SHALL see in_ready=0, Y held and no second transfer; after raising out_ready with in_valid=1, in and out transfers SHALL occur in the same cycle.
REQ-035 With CW=2 and 5 erroneous transfers, err_cnt SHALL read 1,2,3,3,3; err_clr asserted together with an error transfer SHALL give err_cnt=0.
REQ-036 Async reset asserted between clk edges while out_valid=1 SHALL drop out_valid and err_cnt to 0 immediately, and in_ready SHALL be 1 after release.
REQ-037 An exhaustive sweep SHALL cover all 2^N values of D in both modes with N=4, comparing against a reference model.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared definitions for the registered N-to-log2(N) encoder.
package enc_pkg;

  typedef enum logic {
    MODE_PRIO   = 1'b0,
    MODE_ONEHOT = 1'b1
  } mode_e;

  function automatic int unsigned enc_log2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n; v > 1; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/enc_core.sv
// Combinational encoder: priority (highest set bit) or strict one-hot with error flag.
module enc_core
  import enc_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] D,
  input  logic         mode,
  output logic [W-1:0] Y,
  output logic         err_n
);

  logic [W-1:0] hi_idx;
  logic         seen_one;
  logic         seen_many;

  // Upward scan leaves the highest set index; seen_many flags a second set bit.
  always_comb begin
    hi_idx    = '0;
    seen_one  = 1'b0;
    seen_many = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (D[i]) begin
        hi_idx    = W'(i);
        seen_many = seen_many | seen_one;
        seen_one  = 1'b1;
      end
    end
  end

  always_comb begin
    Y     = '0;
    err_n = 1'b0;
    if (mode == MODE_ONEHOT) begin
      if (seen_one && !seen_many) begin
        Y     = hi_idx;
        err_n = 1'b1;
      end
    end else if (seen_one) begin
      Y     = hi_idx;
      err_n = 1'b1;
    end
  end

endmodule

// File: rtl/enc_n_reg.sv
// Encoder with a single-entry valid/ready output register and saturating error counter.
module enc_n_reg
  import enc_pkg::*;
#(
  parameter  int N  = 8,
  parameter  int CW = 8,
  localparam int W  = enc_log2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  D,
  input  logic          mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  Y,
  output logic          _IN_ERR,
  input  logic          err_clr,
  output logic [CW-1:0] err_cnt
);

  logic [W-1:0]  enc_y;
  logic          enc_err_n;
  logic          in_xfer;
  logic          out_xfer;
  logic [W-1:0]  y_q;
  logic          err_n_q;
  logic          valid_q;
  logic [CW-1:0] cnt_q;

  enc_core #(
    .N(N),
    .W(W)
  ) u_core (
    .D    (D),
    .mode (mode),
    .Y    (enc_y),
    .err_n(enc_err_n)
  );

  assign in_ready = !valid_q || out_ready;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = valid_q && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      y_q     <= '0;
      err_n_q <= 1'b1;
    end else if (in_xfer) begin
      valid_q <= 1'b1;
      y_q     <= enc_y;
      err_n_q <= enc_err_n;
    end else if (out_xfer) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (err_clr) begin
      cnt_q <= '0;
    end else if (in_xfer && !enc_err_n && cnt_q != '1) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign out_valid = valid_q;
  assign Y         = y_q;
  assign _IN_ERR   = err_n_q;
  assign err_cnt   = cnt_q;

endmodule
